control_sequencer: RTL and testbench

//  Hardwired control unit directly upstream of the Datapath. Steps T0..T7 per instruction,

---
 rtl/control_sequencer.sv | 136 +++++++++++++
 tb/tb_control_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0..T7 control sequencer for the datapath
// Strobes decode from the present step and the instruction opcode; memory steps wait on mem_rdy.
module control_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run_en,
  input  logic        mem_rdy,
  input  logic [31:0] IR,
  output logic        PC_out,
  output logic        MAR_rd,
  output logic        IncPC,
  output logic        Zlo_rd,
  output logic        Zlo_out,
  output logic        PCin,
  output logic        Read,
  output logic        Write,
  output logic        MDR_rd,
  output logic        MDR_out,
  output logic        IR_rd,
  output logic        Y_rd,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_out,
  output logic        Rin,
  output logic        BAout,
  output logic        C_out,
  output logic [4:0]  op_sel,
  output logic        instr_done,
  output logic        halted,
  output logic        mem_err,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          err;

  logic [4:0] opc;
  logic       is_ld, is_ldi, is_st, is_mem, is_ralu, is_imm, is_halt, is_short;
  logic       wait_state, last_step, step_done;
  logic [4:0] imm_op;
  logic       ir_unused;

  assign opc       = IR[31:27];
  assign ir_unused = ^IR[26:0];  // operand fields are consumed by the datapath, not here
  assign is_ld     = (opc == 5'd0);
  assign is_ldi    = (opc == 5'd1);
  assign is_st     = (opc == 5'd2);
  assign is_mem    = is_ld | is_ldi | is_st;
  assign is_ralu   = (opc >= 5'd3) && (opc <= 5'd11);
  assign is_imm    = (opc >= 5'd12) && (opc <= 5'd14);
  assign is_halt   = (opc == 5'd27);
  assign is_short  = !(is_mem | is_ralu | is_imm | is_halt);
  assign imm_op    = (opc == 5'd13) ? 5'd5 : (opc == 5'd14) ? 5'd6 : 5'd3;

  assign wait_state = (state == T1) || (state == T6 && is_ld) || (state == T7 && is_st);
  assign last_step  = (state == T2 && is_short) ||
                      (state == T5 && (is_ldi | is_ralu | is_imm)) ||
                      (state == T7 && (is_ld | is_st));
  assign step_done  = last_step && (!wait_state || mem_rdy);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (wait_state && !mem_rdy) begin
      if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
        state    <= HALTED;
        err      <= 1'b1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      case (state)
        IDLE:    if (run_en) state <= T0;
        HALTED:  state <= HALTED;
        default: begin
          if (step_done)                  state <= run_en ? T0 : IDLE;
          else if (state == T2 && is_halt) state <= HALTED;
          else                            state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    PC_out = 1'b0; MAR_rd = 1'b0; IncPC = 1'b0; Zlo_rd = 1'b0; Zlo_out = 1'b0;
    PCin = 1'b0; Read = 1'b0; Write = 1'b0; MDR_rd = 1'b0; MDR_out = 1'b0;
    IR_rd = 1'b0; Y_rd = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    R_out = 1'b0; Rin = 1'b0; BAout = 1'b0; C_out = 1'b0; op_sel = 5'd0;
    case (state)
      T0: begin PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1; end
      T1: begin Zlo_out = 1'b1; PCin = 1'b1; Read = 1'b1; MDR_rd = 1'b1; end
      T2: begin MDR_out = 1'b1; IR_rd = 1'b1; end
      T3: begin Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1; BAout = is_mem; end
      T4: begin
        Zlo_rd = 1'b1;
        if (is_ralu) begin
          Grc = 1'b1; R_out = 1'b1; op_sel = opc;
        end else begin
          C_out = 1'b1; op_sel = is_imm ? imm_op : 5'd3;
        end
      end
      T5: begin
        Zlo_out = 1'b1;
        if (is_ld | is_st) MAR_rd = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      T6: begin
        MDR_rd = 1'b1;
        if (is_ld) Read = 1'b1;
        else begin Gra = 1'b1; R_out = 1'b1; end
      end
      T7: begin
        if (is_ld) begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else Write = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_done = step_done;
  assign halted     = (state == HALTED);
  assign mem_err    = halted & err;
  assign state_o    = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and random instruction sequences checked against an expected-step model
module tb_control_sequencer;
  localparam int WAIT_LIMIT = 15;

  localparam logic [26:0] PCO  = 27'd1 << 0,  MARR = 27'd1 << 1,  INCPC = 27'd1 << 2;
  localparam logic [26:0] ZLR  = 27'd1 << 3,  ZLO  = 27'd1 << 4,  PCIN  = 27'd1 << 5;
  localparam logic [26:0] RD   = 27'd1 << 6,  WR   = 27'd1 << 7,  MDRR  = 27'd1 << 8;
  localparam logic [26:0] MDRO = 27'd1 << 9,  IRR  = 27'd1 << 10, YR    = 27'd1 << 11;
  localparam logic [26:0] GRA  = 27'd1 << 12, GRB  = 27'd1 << 13, GRC   = 27'd1 << 14;
  localparam logic [26:0] ROUT = 27'd1 << 15, RIN  = 27'd1 << 16, BAO   = 27'd1 << 17;
  localparam logic [26:0] COUT = 27'd1 << 18, DONE = 27'd1 << 24, HLT   = 27'd1 << 25;
  localparam logic [26:0] ERR  = 27'd1 << 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, run_en, mem_rdy;
  logic [31:0] IR;
  logic PC_out, MAR_rd, IncPC, Zlo_rd, Zlo_out, PCin, Read, Write, MDR_rd, MDR_out, IR_rd;
  logic Y_rd, Gra, Grb, Grc, R_out, Rin, BAout, C_out, instr_done, halted, mem_err;
  logic [4:0] op_sel;
  logic [3:0] state_o;

  control_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .CW(4)) dut (
    .clk(clk), .clr(clr), .run_en(run_en), .mem_rdy(mem_rdy), .IR(IR),
    .PC_out(PC_out), .MAR_rd(MAR_rd), .IncPC(IncPC), .Zlo_rd(Zlo_rd), .Zlo_out(Zlo_out),
    .PCin(PCin), .Read(Read), .Write(Write), .MDR_rd(MDR_rd), .MDR_out(MDR_out),
    .IR_rd(IR_rd), .Y_rd(Y_rd), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_out(R_out),
    .Rin(Rin), .BAout(BAout), .C_out(C_out), .op_sel(op_sel), .instr_done(instr_done),
    .halted(halted), .mem_err(mem_err), .state_o(state_o)
  );

  logic [26:0] obs;
  assign obs = {mem_err, halted, instr_done, op_sel, C_out, BAout, Rin, R_out, Grc, Grb, Gra,
                Y_rd, IR_rd, MDR_out, MDR_rd, Write, Read, PCin, Zlo_out, Zlo_rd, IncPC,
                MAR_rd, PC_out};

  typedef struct {
    logic [26:0] e;
    logic        rdy;
    logic        re;
  } step_t;

  step_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    in_idle;

  function automatic logic rb();
    return $urandom_range(1, 0) == 1;
  endfunction

  function automatic logic [26:0] op(logic [4:0] x);
    return {3'b000, x, 19'd0};
  endfunction

  function automatic void push(logic [26:0] v, logic r, logic en);
    q.push_back('{v, r, en});
  endfunction

  // One memory step: w cycles of waiting, then either completion or a timeout into HALTED.
  function automatic bit wait_step(logic [26:0] v, logic [26:0] extra, int w, logic re);
    for (int i = 0; i < w && i < WAIT_LIMIT; i++) push(v, 1'b0, re);
    if (w >= WAIT_LIMIT) begin
      for (int i = 0; i < 3; i++) push(HLT | ERR, rb(), 1'b1);
      return 1'b1;
    end
    push(v | extra, 1'b1, re);
    return 1'b0;
  endfunction

  // Expected per-cycle outputs for one instruction; returns 1 when it ends in HALTED.
  function automatic bit build(logic [31:0] ir, int t1w, int mw, logic re);
    logic [4:0] opc;
    bit mem, ralu, imm;
    opc  = ir[31:27];
    mem  = opc <= 5'd2;
    ralu = opc >= 5'd3 && opc <= 5'd11;
    imm  = opc >= 5'd12 && opc <= 5'd14;
    q.delete();
    if (in_idle) push(27'd0, rb(), 1'b1);
    push(PCO | MARR | INCPC | ZLR, rb(), re);
    if (wait_step(ZLO | PCIN | RD | MDRR, 27'd0, t1w, re)) return 1'b1;
    if (opc == 5'd27) begin
      push(MDRO | IRR, rb(), re);
      for (int i = 0; i < 3; i++) push(HLT, rb(), 1'b1);
      return 1'b1;
    end
    if (!(mem || ralu || imm)) begin
      push(MDRO | IRR | DONE, rb(), re);
      return 1'b0;
    end
    push(MDRO | IRR, rb(), re);
    push(mem ? (GRB | BAO | ROUT | YR) : (GRB | ROUT | YR), rb(), re);
    if (ralu)     push(GRC | ROUT | ZLR | op(opc), rb(), re);
    else if (imm) push(COUT | ZLR | op(opc == 5'd12 ? 5'd3 : opc == 5'd13 ? 5'd5 : 5'd6), rb(), re);
    else          push(COUT | ZLR | op(5'd3), rb(), re);
    if (opc == 5'd1 || !mem) begin
      push(ZLO | GRA | RIN | DONE, rb(), re);
      return 1'b0;
    end
    push(ZLO | MARR, rb(), re);
    if (opc == 5'd0) begin
      if (wait_step(RD | MDRR, 27'd0, mw, re)) return 1'b1;
      push(MDRO | GRA | RIN | DONE, rb(), re);
    end else begin
      push(GRA | ROUT | MDRR, rb(), re);
      if (wait_step(WR, DONE, mw, re)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called and returns at a falling edge: drive, let inputs settle, compare, advance one clock.
  task automatic cyc(input logic r, input logic en, input logic c, input logic [26:0] e, input string tag);
    mem_rdy = r; run_en = en; clr = c;
    #1;
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic reset_from(input logic [26:0] cur, input string tag);
    cyc(rb(), 1'b1, 1'b0, cur, {tag, "_rst_a"});
    cyc(rb(), 1'b1, 1'b0, 27'd0, {tag, "_rst_b"});
    clr = 1'b1;
    in_idle = 1'b1;
  endtask

  task automatic run(input logic [31:0] ir, input int t1w, input int mw, input logic re,
                     input int abort_idx, input string tag);
    bit h;
    IR = ir;
    h = build(ir, t1w, mw, re);
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_idx) begin
        cyc(q[i].rdy, q[i].re, 1'b0, q[i].e, tag);
        cyc(rb(), 1'b0, 1'b0, 27'd0, {tag, "_abort"});
        clr = 1'b1;
        in_idle = 1'b1;
        return;
      end
      cyc(q[i].rdy, q[i].re, 1'b1, q[i].e, tag);
    end
    if (h) reset_from(q[q.size() - 1].e, tag);
    else   in_idle = !re;
  endtask

  initial begin
    logic [31:0] rir;
    logic [4:0]  ropc;
    int          k, r1, r2;
    clr = 1'b0; run_en = 1'b0; mem_rdy = 1'b0; IR = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(rb(), 1'b0, 1'b0, 27'd0, "reset");
    clr = 1'b1;
    in_idle = 1'b1;
    cyc(rb(), 1'b0, 1'b1, 27'd0, "idle_hold");

    run(32'h11800034, 0, 0, 1'b1, 7, "st_abort_t6");
    cyc(rb(), 1'b0, 1'b1, 27'd0, "after_abort");
    run(32'h11800034, 0, 0, 1'b0, -1, "st");
    run(32'h00900054, 0, 3, 1'b0, -1, "ld_wait3");
    run(32'h1A920000, 0, 0, 1'b0, -1, "add");
    cyc(rb(), 1'b0, 1'b1, 27'd0, "add_idle");
    run(32'h0A800010, 0, 0, 1'b1, -1, "ldi");
    run(32'h69000007, 0, 0, 1'b1, -1, "andi");
    run(32'h00900054, WAIT_LIMIT - 1, WAIT_LIMIT - 1, 1'b1, -1, "ld_wait_max");
    run(32'h11800034, 2, WAIT_LIMIT - 1, 1'b1, -1, "st_wait_max");
    run(32'hD0000000, 0, 0, 1'b1, -1, "nop");
    run(32'hF8000000, 0, 0, 1'b0, -1, "undef");
    run(32'h00900054, WAIT_LIMIT, 0, 1'b1, -1, "timeout_t1");
    run(32'h00900054, 1, WAIT_LIMIT, 1'b1, -1, "timeout_ld");
    run(32'hD8000000, 0, 0, 1'b1, -1, "halt");

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(5, 0);
      case (k)
        0:       ropc = 5'($urandom_range(2, 0));
        1, 5:    ropc = 5'($urandom_range(11, 3));
        2:       ropc = 5'($urandom_range(14, 12));
        3:       ropc = 5'd26;
        default: ropc = 5'($urandom_range(31, 0));
      endcase
      rir = $urandom;
      rir[31:27] = ropc;
      r1 = $urandom_range(19, 0);
      r2 = $urandom_range(19, 0);
      run(rir, r1 < 14 ? r1 % 4 : (r1 < 19 ? 14 : 15),
               r2 < 14 ? r2 % 4 : (r2 < 19 ? 14 : 15), rb(), -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
